// File: rtl/spm_pkg.sv
// Shared types and sizing helpers for the spm host-side driver.
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_SIZE    = 32;
    localparam int DEF_SPM_LAT = 1;

    // Sizes for the default configuration.
    localparam int PROD_W  = 2 * DEF_SIZE;
    localparam int RUN_CYC = 2 * DEF_SIZE + DEF_SPM_LAT;

    // Product width for a given operand width.
    function automatic int prod_w(input int size);
        return 2 * size;
    endfunction

    // RUN length: every product bit plus the spm pipeline latency.
    function automatic int run_cyc(input int size, input int lat);
        return 2 * size + lat;
    endfunction

    // Bits needed to count 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spm_driver_if.sv
// Operand/product handshake bundle between a host and spm_driver.
interface spm_driver_if import spm_pkg::*; #(
    parameter int SIZE = DEF_SIZE
);
    logic                      in_valid;
    logic                      in_ready;
    logic [SIZE-1:0]           a;
    logic [SIZE-1:0]           b;
    logic                      out_valid;
    logic                      out_ready;
    logic [prod_w(SIZE)-1:0]   prod;

    // Host side: offers operands, accepts products.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, prod
    );

    // Driver side.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, prod
    );
endinterface

// File: rtl/spm.sv
// Bit-serial x parallel multiplier: x held in parallel, y LSB-first,
// product LSB-first one cycle after each y bit is sampled. y must be
// sign-extended by the caller to get a two's-complement product.
module spm #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] x,
    input  logic            y,
    output logic            p
);
    // Two guard bits: the shifted accumulator stays within +/-2|x|.
    logic signed [SIZE+1:0] acc;
    logic signed [SIZE+1:0] addend;
    logic signed [SIZE+1:0] sum;

    // Add x when the current multiplier bit is set.
    always_comb begin
        addend = '0;
        if (y) addend = {{2{x[SIZE-1]}}, x};
        sum = acc + addend;
    end

    // Emit the settled LSB, keep the rest for the next weight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            p   <= 1'b0;
        end else begin
            acc <= sum >>> 1;
            p   <= sum[0];
        end
    end
endmodule

// File: rtl/spm_driver.sv
// Host-side controller for spm: loads an operand pair, clears spm for one
// cycle, streams the multiplier bits, and reassembles the serial product.
module spm_driver import spm_pkg::*; #(
    parameter int SIZE    = DEF_SIZE,
    parameter int SPM_LAT = DEF_SPM_LAT
) (
    input  logic            clk,
    input  logic            rst,
    spm_driver_if.slave     bus,
    output logic            spm_rst,
    output logic [SIZE-1:0] spm_x,
    output logic            spm_y,
    input  logic            spm_p
);
    localparam int PW   = prod_w(SIZE);
    localparam int NRUN = run_cyc(SIZE, SPM_LAT);
    localparam int CW   = cnt_w(NRUN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NRUN - 1);
    localparam logic [CW-1:0] CNT_CAP  = CW'(SPM_LAT);

    state_t          state;
    state_t          state_nx;
    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_sh;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   prod_q;

    assign spm_x    = a_q;
    assign bus.prod = prod_q;

    // Next state and handshake outputs; b_sh is sign-filled once the
    // multiplier runs out, so spm_y carries the sign extension for free.
    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        spm_y         = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nx = CLR;
            end
            CLR: state_nx = RUN;
            RUN: begin
                spm_y = b_sh[0];
                if (cnt == CNT_LAST) state_nx = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, operand registers, run counter and product shift register.
    // spm_rst is high exactly for the CLR cycle so leftover spm state from
    // a previous product never leaks into the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            spm_rst <= 1'b1;
            a_q     <= '0;
            b_sh    <= '0;
            cnt     <= '0;
            prod_q  <= '0;
        end else begin
            state   <= state_nx;
            spm_rst <= (state_nx == CLR);
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q  <= bus.a;
                        b_sh <= bus.b;
                    end
                end
                CLR: cnt <= '0;
                RUN: begin
                    cnt  <= cnt + 1'b1;
                    b_sh <= {b_sh[SIZE-1], b_sh[SIZE-1:1]};
                    // First SPM_LAT cycles of spm_p are pipeline fill.
                    if (cnt >= CNT_CAP) prod_q <= {spm_p, prod_q[PW-1:1]};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spm_driver.sv
// Bench for spm_driver + spm at SIZE=8: a cycle-level model derived from the
// handshake/latency rules plus directed operands with literal products.
module tb_spm_driver;
    import spm_pkg::*;

    localparam int SIZE = 8;
    localparam int LAT  = 19;   // handshake edge to out_valid, in edges

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            spm_rst;
    logic [SIZE-1:0] spm_x;
    logic            spm_y;
    logic            spm_p;

    int checks   = 0;
    int failures = 0;

    spm_driver_if #(.SIZE(SIZE)) bus ();

    spm_driver #(.SIZE(SIZE), .SPM_LAT(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .spm_rst (spm_rst),
        .spm_x   (spm_x),
        .spm_y   (spm_y),
        .spm_p   (spm_p)
    );

    spm #(.SIZE(SIZE)) u_spm (
        .clk (clk),
        .rst (rst | spm_rst),
        .x   (spm_x),
        .y   (spm_y),
        .p   (spm_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Cycle model: one operation at a time, result due LAT edges after
    // acceptance, product is the signed 16-bit a*b.
    initial begin
        int          t;
        int          due;
        bit          busy;
        bit          srst_flag;
        bit          ov;
        int          pa;
        int          pb;
        logic [15:0] exp_prod;
        t = 0; due = 0; busy = 0; srst_flag = 1; exp_prod = '0;
        forever begin
            @(negedge clk);
            t++;
            chk("m_spm_rst", {63'd0, spm_rst}, {63'd0, (rst | srst_flag)});
            if (rst) begin
                chk("m_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
                chk("m_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
                chk("m_rst_prod", {48'd0, bus.prod}, 64'd0);
                busy = 0;
                srst_flag = 1;
            end else begin
                ov = busy && (t >= due);
                chk("m_in_ready", {63'd0, bus.in_ready}, {63'd0, !busy});
                chk("m_out_valid", {63'd0, bus.out_valid}, {63'd0, ov});
                if (ov) chk("m_prod", {48'd0, bus.prod}, {48'd0, exp_prod});
                srst_flag = 0;
                if (!busy && bus.in_valid) begin
                    pa = $signed(bus.a);
                    pb = $signed(bus.b);
                    exp_prod = 16'(pa * pb);
                    busy = 1;
                    due = t + LAT;
                    srst_flag = 1;
                end else if (ov && bus.out_ready) begin
                    busy = 0;
                end
            end
        end
    end

    // One operation: wait for in_ready, hand over operands, scramble the
    // inputs, wait for the product, optionally stall in DONE with stray
    // in_valid pulses, then take the product.
    task automatic op(input logic [7:0] ta, input logic [7:0] tb_v,
                      input logic [15:0] want, input int hold, input bit early);
        int n;
        n = 0;
        while (!bus.in_ready && n < 60) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", {63'd0, bus.in_ready}, 64'd1);
        if (early) bus.out_ready = 1'b1;
        bus.a = ta; bus.b = tb_v; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom);
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 64'(n), 64'(LAT));
        chk("prod", {48'd0, bus.prod}, {48'd0, want});
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.a = 8'($urandom); bus.b = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (hold > 0) begin
            chk("hold_prod", {48'd0, bus.prod}, {48'd0, want});
            chk("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        if (!early) bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_prod", {48'd0, bus.prod}, 64'd0);
        chk("rst_spm_rst", {63'd0, spm_rst}, 64'd1);
        chk("rst_spm_x", {56'd0, spm_x}, 64'd0);
        chk("rst_spm_y", {63'd0, spm_y}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        op(8'h03, 8'h05, 16'h000F, 0, 0);
        op(8'hFD, 8'h05, 16'hFFF1, 0, 0);
        op(8'h05, 8'hFD, 16'hFFF1, 0, 0);
        op(8'h80, 8'h80, 16'h4000, 0, 0);
        op(8'h7F, 8'h80, 16'hC080, 0, 0);
        op(8'h00, 8'hAB, 16'h0000, 0, 0);

        // Back-to-back with out_ready held high throughout.
        op(8'h03, 8'h05, 16'h000F, 0, 1);
        op(8'hFF, 8'hFF, 16'h0001, 0, 1);
        bus.out_ready = 1'b0;

        // Stall in DONE for 10 cycles, then a fresh operation.
        op(8'hFF, 8'h02, 16'hFFFE, 10, 0);
        op(8'h03, 8'h05, 16'h000F, 0, 0);

        // Reset in the middle of RUN (cnt == 5).
        bus.a = 8'h03; bus.b = 8'h05; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_prod", {48'd0, bus.prod}, 64'd0);
        chk("midrst_spm_rst", {63'd0, spm_rst}, 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        #1 chk("release_spm_rst", {63'd0, spm_rst}, 64'd1);
        @(posedge clk); #1;
        chk("after_clk_spm_rst", {63'd0, spm_rst}, 64'd0);
        op(8'h03, 8'h05, 16'h000F, 0, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if anything above stalls.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spm_driver.md
Name: spm_driver

Overview:
- Host-side controller for the bit-serial multiplier `spm`.
- Accepts a parallel operand pair through a valid/ready handshake.
- Drives the multiplicand in parallel on `spm_x` and shifts the multiplier out LSB-first on `spm_y`.
- Collects the serial product from `spm_p` into a parallel 2*SIZE-bit result, returned through a second valid/ready handshake.

Parameters:
- SIZE, 32, operand width; must match the `spm` instance size.
- SPM_LAT, 1, cycles from a `spm_y` bit being sampled to the matching `spm_p` bit being valid (registered sum in the first adder stage).

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- in_valid, input, 1, operand pair valid.
- in_ready, output, 1, driver can accept operands.
- a, input, SIZE, multiplicand, two's complement.
- b, input, SIZE, multiplier, two's complement.
- out_valid, output, 1, product valid.
- out_ready, input, 1, consumer accepts product.
- prod, output, 2*SIZE, signed product a*b.
- spm_rst, output, 1, registered clear for `spm`; OR'd with rst at the `spm` instance.
- spm_x, output, SIZE, parallel multiplicand to `spm`.
- spm_y, output, 1, serial multiplier bit to `spm`.
- spm_p, input, 1, serial product bit from `spm`.

Behaviour:
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, prod=0.
  - spm_rst=1, spm_x=0, spm_y=0, cnt=0.
- States: IDLE, CLR, RUN, DONE.
- IDLE:
  - in_ready=1, spm_rst=0.
  - On in_valid: a_q<=a, b_sh<=b, go to CLR.
- CLR (exactly 1 cycle):
  - in_ready=0, spm_rst=1, cnt<=0.
  - spm_x is driven from a_q in every state after the load.
  - Go to RUN. spm_rst deasserts on the edge entering RUN.
- RUN:
  - Total length is N = 2*SIZE + SPM_LAT cycles, cnt = 0..N-1.
  - spm_y = b_sh[0].
  - Each cycle b_sh is arithmetic-shifted right (sign fill), so cycles SIZE..2*SIZE-1 present b[SIZE-1] (sign extension).
  - Cycles cnt >= 2*SIZE drive spm_y = b[SIZE-1].
  - When cnt >= SPM_LAT: prod <= {spm_p, prod[2*SIZE-1:1]} (LSB captured first, ends aligned).
  - At cnt == N-1: go to DONE.
- DONE:
  - out_valid=1 and prod held stable until the out_ready handshake.
  - On out_ready: go to IDLE (out_valid drops the next cycle).
  - in_ready=0 while in DONE.
- Latency: the in handshake to out_valid is 2*SIZE + SPM_LAT + 2 cycles. No overlap between operations.
- Arithmetic: prod is the two's-complement a*b, exact in 2*SIZE bits, including (-2^(SIZE-1))^2.
- in_valid while busy is ignored; the operands are not latched.
- Inputs a/b may change after the handshake without effect (registered in a_q/b_sh).
- out_ready asserted before out_valid has no effect.
- rst mid-operation: immediately returns to IDLE; prod is cleared; out_valid=0; spm_rst=1 until the first clock after rst release.
- cnt width is clog2(N+1); no wrap occurs because the counter is reset in CLR.

Decomposition:
- Package spm_pkg:
  - state enum {IDLE, CLR, RUN, DONE}.
  - localparams PROD_W = 2*SIZE and RUN_CYC = 2*SIZE + SPM_LAT.
  - function cnt_w(n) returning clog2.
- No sub-module needed. The bench instantiates spm_driver and spm (size=SIZE) together, with spm.rst = rst | spm_rst.

Test Plan (SIZE=8, SPM_LAT=1):
- a=3, b=5 → out_valid 19 cycles after the in handshake; prod=0x000F.
- a=-3 (0xFD), b=5 → prod=0xFFF1. a=5, b=-3 → prod=0xFFF1.
- a=0x80, b=0x80 → prod=0x4000. a=0x7F, b=0x80 → prod=0xC080. a=0, b=0xAB → prod=0x0000.
- Back-to-back ops (3*5, then -1*-1) with out_ready held high → second prod=0x0001; the second result is not corrupted by leftover `spm` state.
- Hold out_ready=0 for 10 cycles in DONE → prod and out_valid stable; in_ready=0; in_valid pulses are ignored; the next op runs after the out_ready handshake.
- Assert rst at RUN cnt=5 → state IDLE, out_valid=0, prod=0; after release a fresh 3*5 gives 0x000F.
